// File: rtl/tlc_multiway_ctrl.sv
// rtl/tlc_multiway_ctrl.sv - multi-approach round-robin traffic-light controller with flash override
module tlc_multiway_ctrl #(
    parameter int N_DIR       = 2,
    parameter int CNT_W       = 16,
    parameter int T_MIN_GREEN = 8,
    parameter int T_MAX_GREEN = 32,
    parameter int T_YELLOW    = 4,
    parameter int T_ALL_RED   = 2,
    localparam int IDX_W      = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 tick_i,
    input  logic [N_DIR-1:0]     demand_i,
    input  logic                 flash_i,
    output logic [3*N_DIR-1:0]   lights_o,
    output logic [IDX_W-1:0]     active_o,
    output logic [1:0]           phase_o,
    output logic [N_DIR-1:0]     pend_o
);
    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10,
        PH_FLASH   = 2'b11
    } phase_t;

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALL_RED - 1);

    phase_t             phase;
    logic [IDX_W-1:0]   active;
    logic [CNT_W-1:0]   e;
    logic [N_DIR-1:0]   pend;
    logic               blink;

    logic [N_DIR-1:0]   active_onehot;
    logic [N_DIR-1:0]   pend_next;
    logic               other;
    logic [IDX_W-1:0]   next_idx;
    logic [N_DIR-1:0]   next_onehot;
    logic               found;

    always_comb begin
        active_onehot = N_DIR'(1) << active;
        other         = |(pend & ~active_onehot);
        // The approach holding green does not re-request itself
        pend_next     = pend | (demand_i & ~((phase == PH_GREEN) ? active_onehot : '0));
        next_idx      = active;
        found         = 1'b0;
        for (int k = 1; k <= N_DIR; k++) begin
            if (!found && pend[(int'(active) + k) % N_DIR]) begin
                found    = 1'b1;
                next_idx = IDX_W'((int'(active) + k) % N_DIR);
            end
        end
        next_onehot = N_DIR'(1) << next_idx;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            phase  <= PH_GREEN;
            active <= '0;
            e      <= '0;
            pend   <= '0;
            blink  <= 1'b0;
        end else begin
            pend <= pend_next;
            if (flash_i) begin
                phase <= PH_FLASH;
                e     <= '0;
                if (phase != PH_FLASH)
                    blink <= 1'b0;
                else if (tick_i)
                    blink <= ~blink;
            end else begin
                case (phase)
                    PH_FLASH: begin
                        phase <= PH_ALL_RED;
                        e     <= '0;
                    end
                    PH_GREEN: if (tick_i) begin
                        if (other && ((e >= MIN_LAST && !demand_i[active]) || e >= MAX_LAST)) begin
                            phase <= PH_YELLOW;
                            e     <= '0;
                        end else if (e < MAX_LAST) begin
                            e <= e + CNT_W'(1);
                        end
                    end
                    PH_YELLOW: if (tick_i) begin
                        if (e == Y_LAST) begin
                            phase <= PH_ALL_RED;
                            e     <= '0;
                        end else begin
                            e <= e + CNT_W'(1);
                        end
                    end
                    default: if (tick_i) begin
                        if (e == AR_LAST) begin
                            phase  <= PH_GREEN;
                            active <= next_idx;
                            e      <= '0;
                            pend   <= pend_next & ~next_onehot;
                        end else begin
                            e <= e + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_DIR; i++) begin
            if (phase == PH_FLASH)
                lights_o[3*i +: 3] = blink ? 3'b100 : 3'b000;
            else if (active == IDX_W'(i) && phase == PH_GREEN)
                lights_o[3*i +: 3] = 3'b001;
            else if (active == IDX_W'(i) && phase == PH_YELLOW)
                lights_o[3*i +: 3] = 3'b010;
            else
                lights_o[3*i +: 3] = 3'b100;
        end
    end

    assign active_o = active;
    assign phase_o  = phase;
    assign pend_o   = pend;
endmodule

// File: tb/tb_tlc_multiway_ctrl.sv
// tb/tb_tlc_multiway_ctrl.sv - self-checking bench for tlc_multiway_ctrl (N_DIR=2 and N_DIR=4)
module tb_tlc_multiway_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2, tick2, flash2;
    logic [1:0] dem2;
    logic [5:0] l2;
    logic [0:0] a2;
    logic [1:0] p2, pd2;

    logic       rst4, tick4, flash4;
    logic [3:0] dem4;
    logic [11:0] l4;
    logic [1:0] a4, p4;
    logic [3:0] pd4;

    tlc_multiway_ctrl u2 (
        .wb_clk_i(clk), .wb_rst_i(rst2), .tick_i(tick2), .demand_i(dem2), .flash_i(flash2),
        .lights_o(l2), .active_o(a2), .phase_o(p2), .pend_o(pd2)
    );

    tlc_multiway_ctrl #(.N_DIR(4), .T_MIN_GREEN(3), .T_MAX_GREEN(6), .T_YELLOW(2), .T_ALL_RED(1)) u4 (
        .wb_clk_i(clk), .wb_rst_i(rst4), .tick_i(tick4), .demand_i(dem4), .flash_i(flash4),
        .lights_o(l4), .active_o(a4), .phase_o(p4), .pend_o(pd4)
    );

    // Reference state: e counts ticks since phase entry without saturation
    typedef struct {
        int       ph;
        int       act;
        int       e;
        logic [3:0] pend;
        bit       blink;
    } mst_t;

    mst_t m2, m4;
    int checks = 0;
    int failures = 0;

    function automatic mst_t mstep(mst_t s, int n, int tmin, int tmax, int ty, int tar,
                                   bit rst, bit tick, bit flash, logic [3:0] dem);
        mst_t r;
        bit others;
        bit got;
        int nx;
        r = s;
        if (rst) begin
            r.ph = 0; r.act = 0; r.e = 0; r.pend = '0; r.blink = 0;
            return r;
        end
        for (int i = 0; i < n; i++)
            if (dem[i] && !(s.ph == 0 && i == s.act)) r.pend[i] = 1'b1;
        if (flash) begin
            r.blink = (s.ph == 3) ? (s.blink ^ tick) : 1'b0;
            r.ph = 3; r.e = 0;
            return r;
        end
        if (s.ph == 3) begin
            r.ph = 2; r.e = 0;
        end else if (tick) begin
            if (s.ph == 0) begin
                others = 0;
                for (int j = 0; j < n; j++) if (j != s.act && s.pend[j]) others = 1;
                if (others && ((s.e + 1 >= tmin && !dem[s.act]) || s.e + 1 >= tmax)) begin
                    r.ph = 1; r.e = 0;
                end else r.e = s.e + 1;
            end else if (s.ph == 1) begin
                if (s.e + 1 == ty) begin r.ph = 2; r.e = 0; end else r.e = s.e + 1;
            end else begin
                if (s.e + 1 == tar) begin
                    nx = s.act; got = 0;
                    for (int k = 1; k <= n; k++)
                        if (!got && s.pend[(s.act + k) % n]) begin got = 1; nx = (s.act + k) % n; end
                    r.ph = 0; r.act = nx; r.e = 0; r.pend[nx] = 1'b0;
                end else r.e = s.e + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] mlights(mst_t s, int n);
        logic [11:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (s.ph == 3)                     r[3*i +: 3] = s.blink ? 3'b100 : 3'b000;
            else if (i == s.act && s.ph == 0)  r[3*i +: 3] = 3'b001;
            else if (i == s.act && s.ph == 1)  r[3*i +: 3] = 3'b010;
            else                               r[3*i +: 3] = 3'b100;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m2 = mstep(m2, 2, 8, 32, 4, 2, rst2, tick2, flash2, {2'b00, dem2});
        m4 = mstep(m4, 4, 3, 6, 2, 1, rst4, tick4, flash4, dem4);
        @(negedge clk);
        chk("model2", 32'({2'b00, pd2, 1'b0, a2, p2, 6'b0, l2}),
            32'({m2.pend, 2'(m2.act), 2'(m2.ph), mlights(m2, 2)}));
        chk("model4", 32'({pd4, a4, p4, l4}),
            32'({m4.pend, 2'(m4.act), 2'(m4.ph), mlights(m4, 4)}));
    endtask

    task automatic reset2();
        rst2 = 1; cyc(); cyc(); rst2 = 0;
    endtask

    typedef struct {
        bit rst; bit tick; logic [1:0] dem;
        logic [1:0] ph; logic a; logic [5:0] li; logic [1:0] pd;
    } tv_t;
    tv_t tv[$];

    int tk = 0;
    task automatic tcyc();
        tick2 = (tk % 4 == 0);
        cyc();
        tk++;
    endtask

    initial begin
        int n, glen, ylen, prevph;
        int order[$];
        rst2 = 1; tick2 = 1; flash2 = 0; dem2 = 0;
        rst4 = 1; tick4 = 1; flash4 = 0; dem4 = 0;
        m2 = '{0, 0, 0, 4'b0, 1'b0};
        m4 = '{0, 0, 0, 4'b0, 1'b0};

        // Reset, then one demand pulse for approach 1: 8 green, 4 yellow, 2 all-red, handover
        tv.push_back('{1, 1, 2'b00, 2'd0, 1'b0, 6'b100001, 2'b00});
        tv.push_back('{1, 1, 2'b00, 2'd0, 1'b0, 6'b100001, 2'b00});
        tv.push_back('{0, 1, 2'b10, 2'd0, 1'b0, 6'b100001, 2'b10});
        for (int i = 0; i < 6; i++) tv.push_back('{0, 1, 2'b00, 2'd0, 1'b0, 6'b100001, 2'b10});
        for (int i = 0; i < 4; i++) tv.push_back('{0, 1, 2'b00, 2'd1, 1'b0, 6'b100010, 2'b10});
        for (int i = 0; i < 2; i++) tv.push_back('{0, 1, 2'b00, 2'd2, 1'b0, 6'b100100, 2'b10});
        for (int i = 0; i < 2; i++) tv.push_back('{0, 1, 2'b00, 2'd0, 1'b1, 6'b001100, 2'b00});
        foreach (tv[i]) begin
            rst2 = tv[i].rst; tick2 = tv[i].tick; dem2 = tv[i].dem;
            cyc();
            chk($sformatf("tbl%0d_phase", i), 32'(p2), 32'(tv[i].ph));
            chk($sformatf("tbl%0d_active", i), 32'(a2), 32'(tv[i].a));
            chk($sformatf("tbl%0d_lights", i), 32'(l2), 32'(tv[i].li));
            chk($sformatf("tbl%0d_pend", i), 32'(pd2), 32'(tv[i].pd));
        end

        // Green extension on own demand up to the max
        reset2();
        tick2 = 1; dem2 = 2'b11; cyc(); dem2 = 2'b01;
        glen = 2; n = 0;
        while (p2 == 2'd0 && n < 100) begin cyc(); n++; if (p2 == 2'd0) glen++; end
        chk("ext_green_len", 32'(glen), 32'd32);
        chk("ext_then_yellow", 32'(p2), 32'd1);
        dem2 = 2'b00;

        // N_DIR=4 round-robin from active 1 with pend 1101
        rst4 = 1; cyc(); cyc(); rst4 = 0;
        tick4 = 1; dem4 = 4'b0010; cyc(); dem4 = 4'b0000;
        n = 0;
        while (!(a4 == 2'd1 && p4 == 2'd0) && n < 50) begin cyc(); n++; end
        chk("rr_reach_a1", 32'(n < 50), 32'd1);
        dem4 = 4'b1101; cyc(); dem4 = 4'b0000;
        chk("rr_pend", 32'(pd4), 32'b1101);
        prevph = int'(p4); n = 0;
        while (order.size() < 3 && n < 200) begin
            cyc(); n++;
            if (p4 == 2'd0 && prevph != 0) begin
                order.push_back(int'(a4));
                chk("rr_pend_clear", 32'(pd4[a4]), 32'd0);
            end
            prevph = int'(p4);
        end
        chk("rr_count", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            chk("rr_first", 32'(order[0]), 32'd2);
            chk("rr_second", 32'(order[1]), 32'd3);
            chk("rr_third", 32'(order[2]), 32'd0);
        end
        chk("rr_pend_end", 32'(pd4), 32'd0);

        // Flash override mid-yellow, then release into all-red and next pending green
        reset2();
        tick2 = 1; dem2 = 2'b10; cyc(); dem2 = 2'b00;
        n = 0;
        while (p2 != 2'd1 && n < 40) begin cyc(); n++; end
        chk("fl_reach_yellow", 32'(p2), 32'd1);
        cyc();
        flash2 = 1; cyc();
        chk("fl_phase", 32'(p2), 32'd3);
        chk("fl_dark", 32'(l2), 32'b000000);
        dem2 = 2'b01; cyc(); dem2 = 2'b00;
        chk("fl_red", 32'(l2), 32'b100100);
        cyc();
        chk("fl_dark2", 32'(l2), 32'b000000);
        flash2 = 0; cyc();
        chk("fl_rel_ar1", 32'(p2), 32'd2);
        cyc();
        chk("fl_rel_ar2", 32'(p2), 32'd2);
        cyc();
        chk("fl_green", 32'(p2), 32'd0);
        chk("fl_green_act", 32'(a2), 32'd1);
        chk("fl_pend_kept", 32'(pd2), 32'b01);

        // Slow timebase stretches phases x4; reset pulse mid all-red
        reset2();
        tk = 0; dem2 = 2'b10; tcyc(); dem2 = 2'b00;
        n = 0;
        while (p2 != 2'd1 && n < 200) begin tcyc(); n++; end
        chk("slow_reach_yellow", 32'(p2), 32'd1);
        ylen = 1; n = 0;
        while (p2 == 2'd1 && n < 100) begin tcyc(); n++; if (p2 == 2'd1) ylen++; end
        chk("slow_yellow_len", 32'(ylen), 32'd16);
        tcyc(); tcyc();
        chk("slow_in_allred", 32'(p2), 32'd2);
        rst2 = 1; tcyc(); rst2 = 0;
        chk("rst_phase", 32'(p2), 32'd0);
        chk("rst_lights", 32'(l2), 32'b100001);
        chk("rst_active", 32'(a2), 32'd0);
        chk("rst_pend", 32'(pd2), 32'd0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            rst2 = ($urandom_range(0, 299) == 0);
            rst4 = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 79) == 0) flash2 = ~flash2;
            if ($urandom_range(0, 79) == 0) flash4 = ~flash4;
            tick2 = ($urandom_range(0, 2) != 0);
            tick4 = ($urandom_range(0, 1) != 0);
            for (int b = 0; b < 2; b++) dem2[b] = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < 4; b++) dem4[b] = ($urandom_range(0, 11) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
